// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between CPU and display engine
//
// Purpose: owns the memory en/we/addr/wdata pins and runs one access at a
// time through a fixed IDLE -> ISSUE -> CAPTURE -> ACK sequence. The CPU has
// priority, but a wait counter lets a starved display request win once it has
// been pending for VID_MAX_WAIT cycles.
//
// Ports:
//   clk, reset                   clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata        CPU request, held stable until cpu_ack
//   cpu_ack, cpu_rdata           one-cycle completion pulse, read data (held)
//   vid_req/addr                 display read request, held until vid_ack
//   vid_ack, vid_rdata           one-cycle completion pulse, read data
//   mem_en/we/addr/wdata         memory control, driven only during ISSUE
//   mem_rdata                    memory read data, valid the cycle after ISSUE
//   owner                        0=none, 1=CPU, 2=display
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int VID_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  localparam int WAIT_W = $clog2(VID_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(VID_MAX_WAIT);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_VID  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_ACK     = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_we;

  logic vid_urgent;
  logic grant_cpu;
  logic grant_vid;

  // A display request that has waited long enough overrides the CPU;
  // otherwise the CPU wins any tie.
  assign vid_urgent = vid_req && (wait_cnt >= WAIT_MAX);
  assign grant_vid  = (state_q == S_IDLE) && (vid_urgent || (vid_req && !cpu_req));
  assign grant_cpu  = (state_q == S_IDLE) && cpu_req && !vid_urgent;

  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mem_en  = 1'b0;
    mem_we  = 1'b0;
    cpu_ack = 1'b0;
    vid_ack = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_cpu || grant_vid) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_en  = 1'b1;
        // The display port can never write: lat_we is only set on a CPU grant.
        mem_we  = (owner == OWN_CPU) && lat_we;
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_d = S_ACK;
      end
      S_ACK: begin
        cpu_ack = (owner == OWN_CPU);
        vid_ack = (owner == OWN_VID);
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner     <= OWN_NONE;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      cpu_rdata <= '0;
      vid_rdata <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_vid) begin
            owner    <= OWN_VID;
            lat_addr <= vid_addr;
            lat_we   <= 1'b0;
          end else if (grant_cpu) begin
            owner     <= OWN_CPU;
            lat_addr  <= cpu_addr;
            lat_wdata <= cpu_wdata;
            lat_we    <= cpu_we;
          end
        end
        S_CAPTURE: begin
          if (owner == OWN_CPU && !lat_we) begin
            cpu_rdata <= mem_rdata;
          end else if (owner == OWN_VID) begin
            vid_rdata <= mem_rdata;
          end
        end
        S_ACK: begin
          owner <= OWN_NONE;
        end
        default: begin
        end
      endcase
    end
  end

  // Counts cycles a display request spends pending while the port belongs to
  // someone else (or to nobody but the CPU won), so display latency is bounded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (grant_vid) begin
      wait_cnt <= '0;
    end else if (state_q == S_IDLE && !vid_req) begin
      wait_cnt <= '0;
    end else if (vid_req && owner != OWN_VID && wait_cnt < WAIT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule
